// File: rtl/config_tile_mlane.sv
// Configuration tile for fabric slices: multi-lane shadow shift chain,
// two-step commit (comb config, then register reset-state load), word-count
// length check with sticky error, and readback capture of the active config.
module config_tile_mlane #(
  parameter int unsigned COMB_N = 135,
  parameter int unsigned MEM_N  = 8,
  parameter int unsigned LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_enable,
  input  logic              shift_soft_sel,
  input  logic [LANES-1:0]  shift_in_hard,
  input  logic [LANES-1:0]  shift_in_soft,
  output logic [LANES-1:0]  shift_out,
  input  logic              set_hard,
  input  logic              set_soft,
  input  logic              capture,
  output logic [COMB_N-1:0] comb_config,
  output logic              comb_set,
  output logic [MEM_N-1:0]  mem_config,
  output logic              mem_set,
  output logic              cfg_err
);

  localparam int unsigned CFG_N = COMB_N + MEM_N;
  localparam int unsigned DEPTH = (CFG_N + LANES - 1) / LANES;
  localparam int unsigned SH_N  = LANES * DEPTH;
  localparam int unsigned CNT_W = $clog2(DEPTH + 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    C_COMMIT = 2'd1,
    M_COMMIT = 2'd2
  } state_t;

  state_t            state;
  logic [SH_N-1:0]   shadow;
  logic [SH_N-1:0]   shadow_shifted;
  logic [SH_N-1:0]   shadow_next;
  logic [SH_N-1:0]   capture_img;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [LANES-1:0]  lane_in;
  logic              in_idle;
  logic              do_capture;
  logic              do_shift;
  logic              set_req;
  logic              commit_go;
  logic              commit_bad;

  // Lane tails feed the southward tile directly from the shadow register.
  always_comb begin
    shift_out = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      shift_out[k] = shadow[k*DEPTH];
    end
  end

  // Each lane moves one bit toward its tail; new bit enters at the lane head.
  always_comb begin
    lane_in        = shift_soft_sel ? shift_in_soft : shift_in_hard;
    shadow_shifted = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      shadow_shifted[k*DEPTH +: DEPTH] = {lane_in[k], shadow[k*DEPTH+1 +: DEPTH-1]};
    end
  end

  // Next shadow value and word counter; capture wins over shift, and both
  // are only honoured while idle so the image is frozen during a commit.
  always_comb begin
    in_idle     = (state == IDLE);
    do_capture  = in_idle && capture;
    do_shift    = in_idle && shift_enable && !capture;
    set_req     = set_hard || set_soft;
    commit_go   = in_idle && set_req && (word_cnt == CNT_W'(DEPTH));
    commit_bad  = in_idle && set_req && (word_cnt != CNT_W'(DEPTH));
    capture_img = SH_N'({mem_config, comb_config});

    shadow_next = shadow;
    if (do_capture) begin
      shadow_next = capture_img;
    end else if (do_shift) begin
      shadow_next = shadow_shifted;
    end

    cnt_next = word_cnt;
    if (do_capture || commit_go) begin
      cnt_next = '0;
    end else if (do_shift && (word_cnt != CNT_W'(DEPTH + 1))) begin
      cnt_next = word_cnt + CNT_W'(1);
    end
  end

  // Commit FSM plus shadow/counter/config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      word_cnt    <= '0;
      comb_config <= '0;
      mem_config  <= '0;
      comb_set    <= 1'b0;
      mem_set     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      shadow   <= shadow_next;
      word_cnt <= cnt_next;
      comb_set <= 1'b0;
      mem_set  <= 1'b0;
      case (state)
        IDLE: begin
          if (commit_go) begin
            // Commit the post-shift image when a shift coincides with set.
            comb_config <= shadow_next[COMB_N-1:0];
            mem_config  <= shadow_next[CFG_N-1:COMB_N];
            comb_set    <= 1'b1;
            state       <= C_COMMIT;
          end else if (commit_bad) begin
            cfg_err <= 1'b1;
          end
        end
        C_COMMIT: begin
          mem_set <= 1'b1;
          state   <= M_COMMIT;
        end
        M_COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_tile_mlane.sv
// Directed bench for config_tile_mlane: table of load/commit records plus
// hand-written sequences for short load, readback and reset during commit.
module tb_config_tile_mlane;

  localparam int unsigned COMB_N = 135;
  localparam int unsigned MEM_N  = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DEPTH  = 36;
  localparam int unsigned SH_N   = 144;

  logic              clk;
  logic              rst;
  logic              shift_enable;
  logic              shift_soft_sel;
  logic [LANES-1:0]  shift_in_hard;
  logic [LANES-1:0]  shift_in_soft;
  logic [LANES-1:0]  shift_out;
  logic              set_hard;
  logic              set_soft;
  logic              capture;
  logic [COMB_N-1:0] comb_config;
  logic              comb_set;
  logic [MEM_N-1:0]  mem_config;
  logic              mem_set;
  logic              cfg_err;

  config_tile_mlane #(.COMB_N(COMB_N), .MEM_N(MEM_N), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .shift_enable(shift_enable), .shift_soft_sel(shift_soft_sel),
    .shift_in_hard(shift_in_hard), .shift_in_soft(shift_in_soft),
    .shift_out(shift_out),
    .set_hard(set_hard), .set_soft(set_soft), .capture(capture),
    .comb_config(comb_config), .comb_set(comb_set),
    .mem_config(mem_config), .mem_set(mem_set), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] img;
    int         nw;
    logic       soft_set;
    logic       sw;
    logic       soft_lane;
    logic       pre_cap;
    logic       ok;
    logic       err;
  } rec_t;

  rec_t recs[4];

  int n_vec;
  int n_bad;
  logic [COMB_N-1:0] cur_comb;
  logic [MEM_N-1:0]  cur_mem;
  logic [SH_N-1:0]   t_img;

  function automatic logic [SH_N-1:0] img_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return {1'b0, 8'hC3, 7'h5A, {16{8'hA5}}};
      2'd1:    return {1'b0, 8'h96, 7'h2C, {16{8'h3C}}};
      default: return {1'b0, 8'h5E, 7'h11, {16{8'hE7}}};
    endcase
  endfunction

  // Word j of a stream of 'total' words that leaves image t in the shadow.
  function automatic logic [LANES-1:0] word_of(input logic [SH_N-1:0] t, input int j, input int total);
    logic [LANES-1:0] w;
    int idx;
    idx = j - (total - int'(DEPTH));
    for (int k = 0; k < int'(LANES); k++) begin
      if (idx < 0 || idx > int'(DEPTH) - 1) w[k] = 1'b1;
      else w[k] = t[k*int'(DEPTH) + idx];
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [SH_N-1:0] act, input logic [SH_N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [LANES-1:0] w, input logic soft_lane);
    shift_soft_sel = soft_lane;
    shift_in_soft  = soft_lane ? w : ~w;
    shift_in_hard  = soft_lane ? ~w : w;
  endtask

  task automatic idle_inputs;
    shift_enable = 1'b0;
    set_hard     = 1'b0;
    set_soft     = 1'b0;
    capture      = 1'b0;
    drive_word('0, 1'b0);
  endtask

  task automatic pulse_capture;
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic load_words(input logic [SH_N-1:0] t, input int first, input int n, input int total, input logic soft_lane);
    for (int j = first; j < first + n; j++) begin
      shift_enable = 1'b1;
      drive_word(word_of(t, j, total), soft_lane);
      tick();
    end
    shift_enable = 1'b0;
  endtask

  task automatic chk_cfg(input string nm);
    chk({nm, ".comb"}, SH_N'(comb_config), SH_N'(cur_comb));
    chk({nm, ".mem"}, SH_N'(mem_config), SH_N'(cur_mem));
  endtask

  task automatic run_rec(input rec_t r);
    int total;
    total = r.nw + int'(r.sw);
    t_img = img_of(r.img);
    if (r.pre_cap) pulse_capture();
    load_words(t_img, 0, r.nw, total, r.soft_lane);
    chk("pre_set.comb_set", SH_N'(comb_set), '0);
    set_hard = !r.soft_set;
    set_soft = r.soft_set;
    if (r.sw) begin
      shift_enable = 1'b1;
      drive_word(word_of(t_img, r.nw, total), r.soft_lane);
    end
    tick();
    if (r.ok) begin
      cur_comb = t_img[COMB_N-1:0];
      cur_mem  = t_img[COMB_N+MEM_N-1:COMB_N];
    end
    chk("t1.comb_set", SH_N'(comb_set), SH_N'(r.ok));
    chk("t1.mem_set", SH_N'(mem_set), '0);
    chk("t1.cfg_err", SH_N'(cfg_err), SH_N'(r.err));
    chk_cfg("t1");
    // Holding set/shift into the commit must neither queue nor shift.
    if (!r.ok) idle_inputs();
    tick();
    idle_inputs();
    chk("t2.comb_set", SH_N'(comb_set), '0);
    chk("t2.mem_set", SH_N'(mem_set), SH_N'(r.ok));
    tick();
    chk("t3.mem_set", SH_N'(mem_set), '0);
    chk("t3.comb_set", SH_N'(comb_set), '0);
    chk_cfg("t3");
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    cur_comb = '0;
    cur_mem  = '0;
    //            img   nw  soft_set sw  soft_lane pre_cap ok  err
    recs[0] = '{2'd0, 36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    recs[1] = '{2'd1, 40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    recs[2] = '{2'd1, 35, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    recs[3] = '{2'd1, 36, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset with random inputs.
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      shift_enable   = 1'($urandom);
      shift_soft_sel = 1'($urandom);
      shift_in_hard  = LANES'($urandom);
      shift_in_soft  = LANES'($urandom);
      set_hard       = 1'($urandom);
      set_soft       = 1'($urandom);
      capture        = 1'($urandom);
      tick();
    end
    chk("rst.comb_config", SH_N'(comb_config), '0);
    chk("rst.mem_config", SH_N'(mem_config), '0);
    chk("rst.comb_set", SH_N'(comb_set), '0);
    chk("rst.mem_set", SH_N'(mem_set), '0);
    chk("rst.cfg_err", SH_N'(cfg_err), '0);
    chk("rst.shift_out", SH_N'(shift_out), '0);
    idle_inputs();
    rst = 1'b0;
    tick();

    // Table: full load, over-shift, set+shift at 35 and at 36 words.
    for (int i = 0; i < 4; i++) run_rec(recs[i]);

    // Readback of the committed image, lane tails first.
    t_img = img_of(2'd1);
    pulse_capture();
    for (int j = 0; j < int'(DEPTH); j++) begin
      chk($sformatf("readback.w%0d", j), SH_N'(shift_out), SH_N'(word_of(t_img, j, int'(DEPTH))));
      shift_enable = 1'b1;
      drive_word('0, 1'b0);
      tick();
    end
    idle_inputs();

    // Short load rejected, one more word then accepted; error stays sticky.
    t_img = img_of(2'd2);
    pulse_capture();
    load_words(t_img, 0, 35, int'(DEPTH), 1'b0);
    set_soft = 1'b1;
    tick();
    set_soft = 1'b0;
    chk("short.comb_set", SH_N'(comb_set), '0);
    chk("short.cfg_err", SH_N'(cfg_err), 1);
    chk_cfg("short");
    tick();
    chk("short.mem_set", SH_N'(mem_set), '0);
    load_words(t_img, 35, 1, int'(DEPTH), 1'b1);
    set_hard = 1'b1;
    tick();
    set_hard = 1'b0;
    cur_comb = t_img[COMB_N-1:0];
    cur_mem  = t_img[COMB_N+MEM_N-1:COMB_N];
    chk("fill.comb_set", SH_N'(comb_set), 1);
    chk_cfg("fill");
    tick();
    chk("fill.mem_set", SH_N'(mem_set), 1);
    chk("fill.cfg_err", SH_N'(cfg_err), 1);
    tick();
    chk("fill.mem_set_end", SH_N'(mem_set), '0);

    // Reset during the commit aborts the register-load pulse.
    t_img = img_of(2'd0);
    pulse_capture();
    load_words(t_img, 0, 36, int'(DEPTH), 1'b0);
    set_hard = 1'b1;
    tick();
    set_hard = 1'b0;
    chk("abort.comb_set", SH_N'(comb_set), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.mem_set", SH_N'(mem_set), '0);
    chk("abort.comb_config", SH_N'(comb_config), '0);
    chk("abort.mem_config", SH_N'(mem_config), '0);
    chk("abort.cfg_err", SH_N'(cfg_err), '0);
    chk("abort.shift_out", SH_N'(shift_out), '0);
    tick();
    chk("abort.mem_set_late", SH_N'(mem_set), '0);
    tick();
    chk("abort.mem_set_late2", SH_N'(mem_set), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
